main_decoder: RTL and testbench

- Main control decoder for the RV32I pipeline.
- Maps the 7-bit instruction opcode to datapath control signals: register write enable, immediate format select, ALU B-source select, memory write enable, result select, and ALU operation class.
- Outputs are registered, one per cycle, so they line up with the decode/execute pipeline boundary.
- Feeds the ALU decoder (via ALUOp), the immediate extender (via ImmSrc) and the datapath muxes.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/main_decoder_if.sv | 25 ++
 rtl/main_decoder_comb.sv | 46 ++++
 rtl/main_decoder.sv | 48 ++++
 tb/tb_main_decoder.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, control encodings and the
// control bundle that the main decoder produces.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Field order matches the decode table: RegWrite, ImmSrc, ALUSrc,
  // MemWrite, ResultSrc, ALUOp (8 bits total).
  typedef struct packed {
    logic       reg_write;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic [1:0] alu_op;
  } ctrl_t;

  // All-zero bundle: no register or memory write, safe as a NOP.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/main_decoder_if.sv
// Opcode in / control bundle out for the main decoder.
// There is no valid/ready handshake: op is treated as valid on every cycle
// and the decoder produces a control bundle for every op it sees, so no
// transfer can be stalled or dropped.
interface main_decoder_if;
  logic [6:0] op;
  logic       RegWrite;
  logic [1:0] ImmSrc;
  logic       ALUSrc;
  logic       MemWrite;
  logic       ResultSrc;
  logic [1:0] ALUOp;

  // Instruction source side (pipeline / bench): drives op, reads controls.
  modport master (
    output op,
    input  RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, ALUOp
  );

  // Decoder side: reads op, drives controls.
  modport slave (
    input  op,
    output RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, ALUOp
  );
endinterface

// File: rtl/main_decoder_comb.sv
// Pure combinational opcode-to-control decode. Exact 7-bit match only;
// anything unrecognised decodes to the all-zero NOP bundle, and table
// don't-cares are tied to 0 so no X ever leaves this block.
module main_decoder_comb
  import riscv_pkg::*;
(
  input  logic [6:0] i_op,
  output ctrl_t      o_ctrl
);

  // Decode the opcode into the control bundle, defaulting to NOP.
  always_comb begin
    o_ctrl = CTRL_NOP;
    case (i_op)
      OP_LOAD: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.imm_src    = IMM_I;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.result_src = 1'b1;
        o_ctrl.alu_op     = ALUOP_ADD;
      end
      OP_STORE: begin
        o_ctrl.imm_src   = IMM_S;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BRANCH: begin
        o_ctrl.imm_src = IMM_B;
        o_ctrl.alu_op  = ALUOP_SUB;
      end
      OP_IMM: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.imm_src   = IMM_I;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_REG: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      default: o_ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/main_decoder.sv
// RV32I main control decoder. With REGISTERED=1 the control bundle is
// captured on the rising edge so it lines up with the decode/execute
// boundary; with REGISTERED=0 the bundle is a straight combinational path.
module main_decoder
  import riscv_pkg::*;
#(
  parameter bit REGISTERED = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  main_decoder_if.slave bus
);

  ctrl_t w_ctrl_dec;
  ctrl_t w_ctrl_out;

  main_decoder_comb u_comb (
    .i_op   (bus.op),
    .o_ctrl (w_ctrl_dec)
  );

  generate
    if (REGISTERED) begin : g_reg
      ctrl_t r_ctrl;

      // Capture the decode each edge; reset wins over the decoded op.
      always_ff @(posedge clk) begin
        if (reset) r_ctrl <= CTRL_NOP;
        else       r_ctrl <= w_ctrl_dec;
      end

      assign w_ctrl_out = r_ctrl;
    end else begin : g_comb
      // Clock and reset have no function in the combinational build.
      logic w_unused;
      assign w_unused   = clk ^ reset;
      assign w_ctrl_out = w_ctrl_dec;
    end
  endgenerate

  assign bus.RegWrite  = w_ctrl_out.reg_write;
  assign bus.ImmSrc    = w_ctrl_out.imm_src;
  assign bus.ALUSrc    = w_ctrl_out.alu_src;
  assign bus.MemWrite  = w_ctrl_out.mem_write;
  assign bus.ResultSrc = w_ctrl_out.result_src;
  assign bus.ALUOp     = w_ctrl_out.alu_op;

endmodule

// File: tb/tb_main_decoder.sv
// Bench for main_decoder: a registered instance checked through an expected
// queue (one entry per rising edge) and a combinational instance checked
// directly after op settles.
module tb_main_decoder;

  logic clk;
  logic reset;

  main_decoder_if bus_r ();
  main_decoder_if bus_c ();

  main_decoder #(.REGISTERED(1'b1)) u_dut_r (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_r)
  );

  main_decoder #(.REGISTERED(1'b0)) u_dut_c (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_c)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference decode, packed as {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, ALUOp}.
  function automatic logic [7:0] model(input logic [6:0] op);
    case (op)
      7'b0000011: return 8'b1_00_1_0_1_00;
      7'b0100011: return 8'b0_01_1_1_0_00;
      7'b1100011: return 8'b0_10_0_0_0_01;
      7'b0010011: return 8'b1_00_1_0_0_10;
      7'b0110011: return 8'b1_00_0_0_0_10;
      default:    return 8'b0;
    endcase
  endfunction

  function automatic logic [7:0] obs_r();
    return {bus_r.RegWrite, bus_r.ImmSrc, bus_r.ALUSrc,
            bus_r.MemWrite, bus_r.ResultSrc, bus_r.ALUOp};
  endfunction

  function automatic logic [7:0] obs_c();
    return {bus_c.RegWrite, bus_c.ImmSrc, bus_c.ALUSrc,
            bus_c.MemWrite, bus_c.ResultSrc, bus_c.ALUOp};
  endfunction

  // Pop one expected bundle and compare against the registered outputs.
  task automatic check_reg(input string tag);
    logic [7:0] exp_v;
    logic [7:0] obs_v;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed=%b", tag, obs_r());
    end else begin
      exp_v = exp_q.pop_front();
      obs_v = obs_r();
      assert (obs_v === exp_v) else begin
        n_fail++;
        $error("FAIL %s: observed=%b expected=%b", tag, obs_v, exp_v);
      end
    end
  endtask

  // Combinational instance must follow op immediately, reset ignored.
  task automatic check_comb(input string tag, input logic [6:0] op);
    logic [7:0] exp_v;
    logic [7:0] obs_v;
    exp_v = model(op);
    obs_v = obs_c();
    n_checks++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s_comb: observed=%b expected=%b", tag, obs_v, exp_v);
    end
  endtask

  // Driver: apply op/reset just after an edge, predict, advance one edge, check.
  task automatic step(input string tag, input logic [6:0] op, input logic rst);
    reset    = rst;
    bus_r.op = op;
    bus_c.op = op;
    exp_q.push_back(rst ? 8'b0 : model(op));
    #1;
    check_comb(tag, op);
    @(posedge clk);
    #1;
    check_reg(tag);
  endtask

  initial begin
    logic [6:0] rnd_op;
    logic [6:0] legal_ops[5];
    legal_ops[0] = 7'b0000011;
    legal_ops[1] = 7'b0100011;
    legal_ops[2] = 7'b1100011;
    legal_ops[3] = 7'b0010011;
    legal_ops[4] = 7'b0110011;

    reset    = 1'b1;
    bus_r.op = 7'b0;
    bus_c.op = 7'b0;
    @(posedge clk);
    #1;

    // Reset held for two edges with R-type on op
    step("reset_hold0", 7'b0110011, 1'b1);
    step("reset_hold1", 7'b0110011, 1'b1);
    step("reset_release", 7'b0110011, 1'b0);

    // Load / store
    step("load", 7'b0000011, 1'b0);
    step("store", 7'b0100011, 1'b0);

    // Branch / I-type
    step("branch", 7'b1100011, 1'b0);
    step("itype", 7'b0010011, 1'b0);

    // Illegal opcodes
    step("illegal_ones", 7'b1111111, 1'b0);
    step("illegal_zero", 7'b0000000, 1'b0);
    step("near_load", 7'b0000111, 1'b0);
    step("near_rtype", 7'b1110011, 1'b0);

    // Mid-cycle op change: registered outputs hold until the next edge
    step("mid_load", 7'b0000011, 1'b0);
    #2;
    bus_r.op = 7'b0100011;
    bus_c.op = 7'b0100011;
    exp_q.push_back(model(7'b0000011));
    #1;
    check_reg("mid_hold_load");
    check_comb("mid_switch", 7'b0100011);
    exp_q.push_back(model(7'b0100011));
    @(posedge clk);
    #1;
    check_reg("mid_store_after_edge");

    // Reset asserted mid-stream with I-type held
    step("stream_itype", 7'b0010011, 1'b0);
    step("stream_reset", 7'b0010011, 1'b1);
    step("stream_recover", 7'b0010011, 1'b0);

    // Random mix of legal and arbitrary opcodes, occasional reset
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) rnd_op = legal_ops[$urandom_range(0, 4)];
      else                           rnd_op = 7'($urandom_range(0, 127));
      step("random", rnd_op, ($urandom_range(0, 9) == 0));
    end

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_drain: observed=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
